store_queue: RTL

//  Circular store queue that sits beside the reorder_buffer and consumes its commit output.
//  - Allocates an entry per dispatched STORE.
//  - Captures the store address from the AGU and the store data from the CDB.
//  - Marks the entry committed when the ROB retires that store.
//  - Drains committed stores in program order to the data-memory write port over a

---
 rtl/store_queue_if.sv | 24 ++
 rtl/store_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/store_queue_if.sv
// Memory write port between the store queue (master) and the data memory (slave).
// The store queue presents one store per transfer; memory accepts it with mem_wr_ready.
interface store_queue_if #(
   parameter int XLEN = 32
);
   logic            mem_wr_valid;
   logic [XLEN-1:0] mem_wr_addr;
   logic [XLEN-1:0] mem_wr_data;
   logic            mem_wr_ready;

   modport master (
      output mem_wr_valid,
      output mem_wr_addr,
      output mem_wr_data,
      input  mem_wr_ready
   );

   modport slave (
      input  mem_wr_valid,
      input  mem_wr_addr,
      input  mem_wr_data,
      output mem_wr_ready
   );
endinterface

// File: rtl/store_queue.sv
// Circular store queue beside the reorder buffer.
// Entries are allocated at dispatch, collect their address (AGU) and data (CDB) by ROB tag,
// are marked committed when the ROB retires them, and drain in order to the memory write port.
// Per-entry valid/tag vectors are exported so the flush logic can pick a new tail.
module store_queue #(
   parameter int XLEN          = 32,
   parameter int ROB_TAG_WIDTH = 4,
   parameter int STQ_SIZE      = 8,
   parameter int STQ_TAG_WIDTH = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              alloc_en_i,
   input  logic [ROB_TAG_WIDTH-1:0]          alloc_rob_tag_i,
   input  logic                              agu_address_valid_i,
   input  logic [XLEN-1:0]                   agu_address_data_i,
   input  logic [ROB_TAG_WIDTH-1:0]          agu_address_rob_tag_i,
   input  logic                              cdb_valid_i,
   input  logic [XLEN-1:0]                   cdb_data_i,
   input  logic [ROB_TAG_WIDTH-1:0]          cdb_rob_tag_i,
   input  logic                              rob_commit_i,
   input  logic [ROB_TAG_WIDTH-1:0]          rob_head_i,
   input  logic                              flush_stq_i,
   input  logic [STQ_TAG_WIDTH-1:0]          stq_new_tail_i,
   store_queue_if.master                     mem_if,
   output logic [STQ_SIZE-1:0]               stq_valid_o,
   output logic [STQ_SIZE*ROB_TAG_WIDTH-1:0] stq_rob_tag_o,
   output logic [STQ_SIZE-1:0]               stq_committed_o,
   output logic [STQ_TAG_WIDTH-1:0]          head_o,
   output logic [STQ_TAG_WIDTH-1:0]          tail_o,
   output logic                              full_o,
   output logic                              empty_o
);

   // Control state: per-entry flags and the two ring pointers (reset-cleared)
   logic [STQ_SIZE-1:0]      valid_q,    valid_d;
   logic [STQ_SIZE-1:0]      addr_vld_q, addr_vld_d;
   logic [STQ_SIZE-1:0]      data_vld_q, data_vld_d;
   logic [STQ_SIZE-1:0]      cmt_q,      cmt_d;
   logic [STQ_TAG_WIDTH-1:0] head_q,     head_d;
   logic [STQ_TAG_WIDTH-1:0] tail_q,     tail_d;

   // Payload state: only meaningful while the matching flag is set, so never reset
   logic [ROB_TAG_WIDTH-1:0] tag_q  [STQ_SIZE];
   logic [ROB_TAG_WIDTH-1:0] tag_d  [STQ_SIZE];
   logic [XLEN-1:0]          addr_q [STQ_SIZE];
   logic [XLEN-1:0]          addr_d [STQ_SIZE];
   logic [XLEN-1:0]          data_q [STQ_SIZE];
   logic [XLEN-1:0]          data_d [STQ_SIZE];

   logic                     full;
   logic                     empty;
   logic                     head_ready;
   logic                     drain_fire;
   logic                     alloc_fire;
   logic [STQ_TAG_WIDTH-1:0] flush_len;
   logic [STQ_SIZE-1:0]      flush_mask;

   // head==tail is ambiguous on the pointers alone; occupancy comes from the valid bits
   assign full  = &valid_q;
   assign empty = ~|valid_q;

   // The head entry is ready to write once it is committed and both operands have arrived
   assign head_ready = valid_q[head_q] & cmt_q[head_q] & addr_vld_q[head_q] & data_vld_q[head_q];
   assign drain_fire = head_ready & mem_if.mem_wr_ready;

   // A full queue refuses allocation even if the head drains this cycle; flush also blocks it
   assign alloc_fire = alloc_en_i & ~full & ~flush_stq_i;

   // Select the indices being squashed: [new_tail, tail) modulo the ring size.
   // An empty range on a full queue means "everything after the committed stores".
   always_comb begin
      flush_len  = tail_q - stq_new_tail_i;
      flush_mask = '0;
      for (int i = 0; i < STQ_SIZE; i++) begin
         if (flush_stq_i) begin
            if (flush_len == '0) begin
               flush_mask[i] = full & ~cmt_q[i];
            end else begin
               flush_mask[i] = STQ_TAG_WIDTH'(STQ_TAG_WIDTH'(i) - stq_new_tail_i) < flush_len;
            end
         end
      end
   end

   // Next-state for every entry: capture, commit, drain, flush, then allocate
   always_comb begin
      valid_d    = valid_q;
      addr_vld_d = addr_vld_q;
      data_vld_d = data_vld_q;
      cmt_d      = cmt_q;
      head_d     = head_q;
      tail_d     = tail_q;
      tag_d      = tag_q;
      addr_d     = addr_q;
      data_d     = data_q;

      // Tag-matched capture and commit only touch live entries that survive a flush.
      // The entry being allocated is not yet valid, so it cannot capture this cycle.
      for (int i = 0; i < STQ_SIZE; i++) begin
         if (valid_q[i] && !flush_mask[i]) begin
            if (agu_address_valid_i && (tag_q[i] == agu_address_rob_tag_i)) begin
               addr_d[i]     = agu_address_data_i;
               addr_vld_d[i] = 1'b1;
            end
            if (cdb_valid_i && (tag_q[i] == cdb_rob_tag_i)) begin
               data_d[i]     = cdb_data_i;
               data_vld_d[i] = 1'b1;
            end
            if (rob_commit_i && !cmt_q[i] && (tag_q[i] == rob_head_i)) begin
               cmt_d[i] = 1'b1;
            end
         end
      end

      // Retire the head entry once memory has taken it
      if (drain_fire) begin
         valid_d[head_q]    = 1'b0;
         addr_vld_d[head_q] = 1'b0;
         data_vld_d[head_q] = 1'b0;
         cmt_d[head_q]      = 1'b0;
         head_d             = head_q + STQ_TAG_WIDTH'(1);
      end

      // Squash the selected entries and rewind the tail
      if (flush_stq_i) begin
         for (int i = 0; i < STQ_SIZE; i++) begin
            if (flush_mask[i]) begin
               valid_d[i]    = 1'b0;
               addr_vld_d[i] = 1'b0;
               data_vld_d[i] = 1'b0;
               cmt_d[i]      = 1'b0;
            end
         end
         tail_d = stq_new_tail_i;
      end

      // New store at the tail starts with only its tag known
      if (alloc_fire) begin
         valid_d[tail_q]    = 1'b1;
         tag_d[tail_q]      = alloc_rob_tag_i;
         addr_vld_d[tail_q] = 1'b0;
         data_vld_d[tail_q] = 1'b0;
         cmt_d[tail_q]      = 1'b0;
         tail_d             = tail_q + STQ_TAG_WIDTH'(1);
      end
   end

   // Control registers with synchronous reset that overrides all other activity
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= '0;
         addr_vld_q <= '0;
         data_vld_q <= '0;
         cmt_q      <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         addr_vld_q <= addr_vld_d;
         data_vld_q <= data_vld_d;
         cmt_q      <= cmt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Payload registers; stale contents are masked by the flags
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      addr_q <= addr_d;
      data_q <= data_d;
   end

   // Memory write port driven straight from registered head state, zeroed when idle
   always_comb begin
      mem_if.mem_wr_valid = head_ready;
      mem_if.mem_wr_addr  = head_ready ? addr_q[head_q] : '0;
      mem_if.mem_wr_data  = head_ready ? data_q[head_q] : '0;
   end

   // Status exports for the flush logic and observers
   always_comb begin
      stq_rob_tag_o = '0;
      for (int i = 0; i < STQ_SIZE; i++) begin
         stq_rob_tag_o[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH] = tag_q[i];
      end
   end

   assign stq_valid_o     = valid_q;
   assign stq_committed_o = cmt_q;
   assign head_o          = head_q;
   assign tail_o          = tail_q;
   assign full_o          = full;
   assign empty_o         = empty;

endmodule
